// File: rtl/my_nios1_nios2_processor_cpu_debug_ocimem_ctl.sv
// Purpose : JTAG debug-slave controller that turns debug commands into debug-RAM reads/writes.
// Latency : strobe to monitor_ready = 1 (address load), 2 (write), 3 (read) cycles plus waitrequest stalls.
// Backpress: ocimem_waitrequest holds the request stable; TIMEOUT consecutive stalls abort the transfer.
//
// Ports:
//   clk, reset                       - single clock, synchronous active-high reset
//   jdo[37:0]                        - debug data word: [34] error clear, [34:3] write data,
//                                      [25:18] address, [17] read-after-load
//   take_action_ocimem_a/_b,
//   take_no_action_ocimem_a          - one-cycle command strobes (a > b > no_action)
//   ocimem_address/read/write/
//   writedata/readdata/waitrequest   - debug-RAM master port
//   MonDReg, monitor_ready,
//   monitor_error                    - status returned to the JTAG stage
module my_nios1_nios2_processor_cpu_debug_ocimem_ctl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] ocimem_address,
    output logic              ocimem_read,
    output logic              ocimem_write,
    output logic [31:0]       ocimem_writedata,
    input  logic [31:0]       ocimem_readdata,
    input  logic              ocimem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_DATA, WR_REQ} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         mon_q, mon_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                rdy_q, rdy_d;
    logic                err_q, err_d;

    logic                any_strobe;
    logic                accept;
    logic                expire;

    // jdo bits outside the command fields carry nothing for this block.
    logic unused_jdo_bits;
    assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign accept     = ~ocimem_waitrequest;
    // This cycle would be the TIMEOUT-th consecutive stall; acceptance always wins.
    assign expire     = ocimem_waitrequest && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        mon_d   = mon_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdy_d   = rdy_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    addr_d = ADDR_W'(jdo[25:18]);
                    if (jdo[17]) begin
                        state_d = RD_REQ;
                        rd_d    = 1'b1;
                        rdy_d   = 1'b0;
                    end else begin
                        rdy_d   = 1'b1;
                    end
                end else if (take_action_ocimem_b) begin
                    state_d = WR_REQ;
                    wr_d    = 1'b1;
                    wdata_d = jdo[34:3];
                    rdy_d   = 1'b0;
                end else if (take_no_action_ocimem_a) begin
                    state_d = RD_REQ;
                    rd_d    = 1'b1;
                    rdy_d   = 1'b0;
                end
            end
            RD_REQ: begin
                if (accept) begin
                    state_d = RD_DATA;
                    rd_d    = 1'b0;
                    cnt_d   = '0;
                end else if (expire) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    rdy_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            RD_DATA: begin
                // Read data is valid exactly one cycle after acceptance.
                state_d = IDLE;
                mon_d   = ocimem_readdata;
                addr_d  = addr_q + ADDR_W'(1);
                rdy_d   = 1'b1;
            end
            WR_REQ: begin
                if (accept) begin
                    state_d = IDLE;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    mon_d   = wdata_q;
                    addr_d  = addr_q + ADDR_W'(1);
                    rdy_d   = 1'b1;
                end else if (expire) begin
                    state_d = IDLE;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    rdy_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase

        // Commands arriving while busy are dropped and flagged.
        if (state_q != IDLE && any_strobe) begin
            err_d = 1'b1;
        end
        // Clear beats any set in the same cycle.
        if (take_action_ocimem_a && jdo[34]) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            mon_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            mon_q   <= mon_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    assign ocimem_address   = addr_q;
    assign ocimem_read      = rd_q;
    assign ocimem_write     = wr_q;
    assign ocimem_writedata = wdata_q;
    assign MonDReg          = mon_q;
    assign monitor_ready    = rdy_q;
    assign monitor_error    = err_q;

endmodule

// File: tb/tb_my_nios1_nios2_processor_cpu_debug_ocimem_ctl.sv
// Purpose : self-checking bench for the debug-RAM controller with a behavioural RAM and command model.
// Latency : checks strobe-to-ready latency per command type including programmed stalls.
// Backpress: a RAM responder stalls each request for a programmable number of cycles.
module tb_my_nios1_nios2_processor_cpu_debug_ocimem_ctl;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        act_a = 1'b0, act_b = 1'b0, noact_a = 1'b0;
    logic [7:0]  ocimem_address;
    logic        ocimem_read, ocimem_write;
    logic [31:0] ocimem_writedata, ocimem_readdata, MonDReg;
    logic        ocimem_waitrequest, monitor_ready, monitor_error;

    int total = 0;
    int bad   = 0;
    int stall_n = 0;
    int wait_cnt = 0;
    logic both_seen = 1'b0;
    logic [31:0] mem [0:255];
    logic [31:0] m_mem [0:255];

    always #5 clk = ~clk;

    my_nios1_nios2_processor_cpu_debug_ocimem_ctl #(.ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (act_a),
        .take_action_ocimem_b    (act_b),
        .take_no_action_ocimem_a (noact_a),
        .ocimem_address          (ocimem_address),
        .ocimem_read             (ocimem_read),
        .ocimem_write            (ocimem_write),
        .ocimem_writedata        (ocimem_writedata),
        .ocimem_readdata         (ocimem_readdata),
        .ocimem_waitrequest      (ocimem_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    // RAM responder: stalls each request stall_n cycles, returns data one cycle after acceptance.
    assign ocimem_waitrequest = (ocimem_read || ocimem_write) && (wait_cnt < stall_n);

    always @(posedge clk) begin
        if (ocimem_read || ocimem_write) wait_cnt <= wait_cnt + 1;
        else                             wait_cnt <= 0;
        if (ocimem_read && ocimem_write) both_seen <= 1'b1;
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i[7:0]);
        end else if (ocimem_write && !ocimem_waitrequest) begin
            mem[ocimem_address] <= ocimem_writedata;
        end
        if (ocimem_read && !ocimem_waitrequest) ocimem_readdata <= mem[ocimem_address];
        else                                    ocimem_readdata <= $urandom;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_a(input logic clr, input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j = '0;
        j[34] = clr;
        j[25:18] = a;
        j[17] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic pulse(input logic a, input logic b, input logic na, input logic [37:0] j);
        act_a = a; act_b = b; noact_a = na; jdo = j;
        step();
        act_a = 1'b0; act_b = 1'b0; noact_a = 1'b0;
    endtask

    // Latency counted from the strobe cycle; bounded so a hung DUT shows up as a wrong latency.
    task automatic wait_ready(output int lat);
        lat = 1;
        while (!monitor_ready && lat < 600) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int cmd;
        int s;
        logic [7:0] m_addr;
        logic [7:0] na;
        logic [31:0] m_mon;
        logic [31:0] d;

        // Reset, with a strobe during reset that must be ignored.
        #1;
        act_a = 1'b1; jdo = jdo_a(1'b0, 8'h77, 1'b1);
        step(); step();
        act_a = 1'b0;
        chk("rst_addr", ocimem_address, 8'h00);
        chk("rst_rd_wr", {ocimem_read, ocimem_write}, 2'b00);
        chk("rst_wdata", ocimem_writedata, 32'h0);
        chk("rst_mon", MonDReg, 32'h0);
        chk("rst_rdy_err", {monitor_ready, monitor_error}, 2'b00);
        reset = 1'b0;
        step();
        chk("post_rst_idle", {ocimem_read, monitor_ready, ocimem_address}, {1'b0, 1'b0, 8'h00});

        // Write then read back.
        pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'h10, 1'b0));
        chk("load_ready_1cyc", monitor_ready, 1'b1);
        chk("load_addr", ocimem_address, 8'h10);
        pulse(1'b0, 1'b1, 1'b0, jdo_b(32'hDEADBEEF));
        chk("wr_req", {ocimem_write, ocimem_read, ocimem_address, monitor_ready}, {1'b1, 1'b0, 8'h10, 1'b0});
        chk("wr_data", ocimem_writedata, 32'hDEADBEEF);
        step();
        chk("wr_done", {ocimem_write, monitor_ready, ocimem_address}, {1'b0, 1'b1, 8'h11});
        chk("wr_mon", MonDReg, 32'hDEADBEEF);
        pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'h10, 1'b1));
        chk("rd_req", {ocimem_read, ocimem_address, monitor_ready}, {1'b1, 8'h10, 1'b0});
        step();
        chk("rd_cycle2", {ocimem_read, monitor_ready}, 2'b00);
        step();
        chk("rd_ready_3cyc", monitor_ready, 1'b1);
        chk("rd_mon", MonDReg, 32'hDEADBEEF);
        chk("rd_addr_inc", ocimem_address, 8'h11);

        // Streaming reads across the address wrap.
        pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'hFF, 1'b0));
        pulse(1'b0, 1'b0, 1'b1, '0);
        chk("stream_addr_ff", {ocimem_read, ocimem_address}, {1'b1, 8'hFF});
        wait_ready(lat);
        chk("stream_mon_ff", MonDReg, init_val(8'hFF));
        pulse(1'b0, 1'b0, 1'b1, '0);
        chk("stream_addr_00", {ocimem_read, ocimem_address}, {1'b1, 8'h00});
        wait_ready(lat);
        chk("stream_mon_00", MonDReg, init_val(8'h00));
        chk("stream_final_addr", ocimem_address, 8'h01);

        // 10-cycle stall: request held stable, then succeeds.
        stall_n = 10;
        pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'h20, 1'b1));
        for (int i = 0; i < 10; i++) begin
            chk("stall_hold", {ocimem_read, ocimem_address}, {1'b1, 8'h20});
            step();
        end
        step();
        chk("stall_accepted", ocimem_read, 1'b0);
        step();
        chk("stall_done", {monitor_ready, monitor_error, ocimem_address}, {1'b1, 1'b0, 8'h21});
        chk("stall_mon", MonDReg, init_val(8'h20));

        // Timeout after TIMEOUT stalls.
        stall_n = TIMEOUT;
        pulse(1'b0, 1'b0, 1'b1, '0);
        wait_ready(lat);
        chk("timeout_lat", lat, TIMEOUT + 1);
        chk("timeout_flags", {monitor_error, monitor_ready, ocimem_read}, 3'b110);
        chk("timeout_addr", ocimem_address, 8'h21);
        chk("timeout_mon", MonDReg, init_val(8'h20));

        // One stall fewer succeeds; error clear rides on the same command.
        stall_n = TIMEOUT - 1;
        pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 8'h30, 1'b1));
        chk("clear_err", monitor_error, 1'b0);
        wait_ready(lat);
        chk("edge_lat", lat, TIMEOUT + 2);
        chk("edge_ok", {monitor_error, ocimem_address}, {1'b0, 8'h31});
        chk("edge_mon", MonDReg, init_val(8'h30));

        // Write strobe while a read is in flight.
        stall_n = 3;
        pulse(1'b0, 1'b0, 1'b1, '0);
        pulse(1'b0, 1'b1, 1'b0, jdo_b(32'h12345678));
        chk("busy_drop", {ocimem_write, ocimem_read, monitor_error}, 3'b011);
        wait_ready(lat);
        chk("busy_rd_done", {MonDReg, ocimem_address}, {init_val(8'h31), 8'h32});
        chk("busy_err_sticky", monitor_error, 1'b1);
        pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 8'h32, 1'b0));
        chk("busy_err_clear", {monitor_error, monitor_ready}, 2'b01);

        // Reset during a stalled read.
        stall_n = 5;
        pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'h40, 1'b1));
        step();
        reset = 1'b1;
        step();
        chk("midrst", {ocimem_read, MonDReg, ocimem_address}, {1'b0, 32'h0, 8'h00});
        reset = 1'b0;
        step();

        // Simultaneous a and b: only the address load happens.
        pulse(1'b1, 1'b1, 1'b0, jdo_a(1'b0, 8'h55, 1'b0));
        chk("prio_load", {ocimem_write, ocimem_read, monitor_ready, ocimem_address}, {1'b0, 1'b0, 1'b1, 8'h55});
        step();
        chk("prio_no_wr", {ocimem_write, monitor_error}, 2'b00);

        // Random commands against a transaction-level model.
        for (int i = 0; i < 256; i++) m_mem[i] = init_val(i[7:0]);
        m_addr = 8'h55;
        m_mon  = 32'h0;
        for (int k = 0; k < 60; k++) begin
            cmd = $urandom_range(0, 3);
            s   = $urandom_range(0, 4);
            na  = 8'($urandom_range(0, 255));
            d   = $urandom;
            stall_n = s;
            case (cmd)
                0: begin
                    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, na, 1'b0));
                    m_addr = na;
                end
                1: begin
                    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, na, 1'b1));
                    m_mon = m_mem[na];
                    m_addr = na + 8'd1;
                end
                2: begin
                    pulse(1'b0, 1'b1, 1'b0, jdo_b(d));
                    m_mem[m_addr] = d;
                    m_mon = d;
                    m_addr = m_addr + 8'd1;
                end
                default: begin
                    pulse(1'b0, 1'b0, 1'b1, '0);
                    m_mon = m_mem[m_addr];
                    m_addr = m_addr + 8'd1;
                end
            endcase
            wait_ready(lat);
            chk("rand_lat", lat, (cmd == 0) ? 1 : (cmd == 2) ? 2 + s : 3 + s);
            chk("rand_addr", ocimem_address, m_addr);
            chk("rand_mon", MonDReg, m_mon);
            chk("rand_err", monitor_error, 1'b0);
        end

        chk("rd_wr_exclusive", both_seen, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
